ldm_stm_seq: RTL and testbench
==============================

LDM_STM_SEQ -- requirements
Module: ldm_stm_seq

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have: i_start  in  1  begin block transfer; i_load  in  1  1=LDM, 0=STM; i_pre  in  1  P bit; i_up  in  1  U bit; i_wb  in  1  W bit.
REQ-003 SHALL have: i_rn_code  in  4  base register code; i_rn_reg  in  32  base value; i_reg_list  in  16  register list.
REQ-004 SHALL have: o_busy  out  1  transfer in progress; o_done  out  1  one-cycle completion pulse.
REQ-005 SHALL have: o_re_code  out  4  store-data read code to register file; i_re_reg  in  32  read value.
REQ-006 SHALL have: o_mem_req  out  1; o_mem_we  out  1; o_mem_addr  out  32; o_mem_wdata  out  32; i_mem_ack  in  1; i_mem_rdata  in  32.
REQ-007 SHALL have: o_rd_en_wb  out  1; o_rd_code_wb  out  4; o_rd_reg_wb  out  32 for loaded data; o_rd_en_ex  out  1; o_rd_code_ex  out  4; o_rd_reg_ex  out  32 for base writeback.

Function
REQ-008 SHALL implement states IDLE, XFER, DONE.
REQ-009 In IDLE, i_start=1 SHALL latch all command inputs, n=popcount(i_reg_list), and the final base value, then enter XFER next cycle (DONE if n=0).
REQ-010 Start address SHALL be: IA base; IB base+4; DA base-4n+4; DB base-4n. Addresses SHALL ascend by 4 per transfer, with 32-bit wrap-around.
REQ-011 Registers SHALL be transferred lowest code first; the current register SHALL be the lowest set bit of the remaining list.
REQ-012 In XFER, o_mem_req=1 and o_mem_we=!load. Addr, wdata and o_re_code SHALL stay stable until i_mem_ack is sampled high.
REQ-013 For stores, o_re_code SHALL equal the current code and o_mem_wdata SHALL equal i_re_reg, passed through combinationally.
REQ-014 On an ack cycle, the sequencer SHALL clear the current list bit and add 4 to the address. On the last ack it SHALL enter DONE; otherwise it SHALL stay in XFER with the next request presented in the following cycle.
REQ-015 For loads, rdata SHALL be captured on the ack cycle; o_rd_en_wb SHALL pulse exactly one cycle later with the loaded code and captured data. Code 15 SHALL be allowed; it signals a PC write downstream.
REQ-016 DONE SHALL last one cycle: o_done=1. If i_wb=1, o_rd_en_ex=1 with o_rd_code_ex=base code and o_rd_reg_ex=base±4n. The block SHALL return to IDLE next.
REQ-017 Base writeback SHALL be suppressed when i_load=1 and the base is in the list (loaded value wins), and when n=0.
REQ-018 n=0 SHALL produce no memory request and no register write; o_done SHALL pulse one cycle after start.
REQ-019 i_start SHALL be ignored while o_busy=1.
REQ-020 o_busy SHALL be 1 in XFER and DONE, and 0 in IDLE.
REQ-021 The last load's o_rd_en_wb SHALL coincide with DONE; the WB and EX ports may both be active in that cycle.

Reset
REQ-022 rst SHALL force IDLE and SHALL drive o_busy, o_done, o_mem_req, o_mem_we, o_rd_en_wb and o_rd_en_ex to 0. Codes and data outputs SHALL reset to 0.
REQ-023 rst mid-transfer SHALL abort the transfer: req SHALL drop at the next edge, with no further register writes and no base writeback.

Structure
REQ-024 State encodings and addressing-mode constants (IA/IB/DA/DB) SHALL reside in the shared core definitions package.
REQ-025 A sub-module lowest_set_bit (16-bit in, 4-bit code plus valid out, combinational) SHALL select the current register.

Verification
REQ-026 LDMIA r0!,{r1,r2,r4}, r0=0x1000, zero-wait ack: addrs 0x1000/0x1004/0x1008; WB pulses codes 1,2,4 with rdata; EX writes r0=0x100C.
REQ-027 STMDB r13!,{r4,r14}, r13=0x2000: writes at 0x1FF8 (o_re_code=4) then 0x1FFC (o_re_code=14) with wdata=i_re_reg; EX writes r13=0x1FF8.
REQ-028 LDMIB r3!,{r3,r5}, r3=0x400: addrs 0x404, 0x408; WB writes r3 then r5; o_rd_en_ex never asserts.
REQ-029 STMIA with ack delayed 3 cycles per beat: req, addr and wdata stable across the wait states; no beat skipped; o_done one cycle after the final ack.
REQ-030 Empty list with start: no o_mem_req; o_done one cycle later; start pulsed during a busy transfer is ignored.
REQ-031 rst asserted after the first ack of a 4-register LDM: o_mem_req=0 and o_busy=0 the next cycle; no subsequent WB or EX writes.

Source files
------------

// File: rtl/ldm_stm_seq_pkg.sv
// Shared core definitions for the block-transfer sequencer.
//   state_t     : sequencer states (IDLE / XFER / DONE)
//   AM_*        : addressing modes, encoded as {P, U}
//   popcount16  : number of registers named in a 16-bit register list
package ldm_stm_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [1:0] am_t;

  localparam am_t AM_DA = 2'b00;  // decrement after
  localparam am_t AM_IA = 2'b01;  // increment after
  localparam am_t AM_DB = 2'b10;  // decrement before
  localparam am_t AM_IB = 2'b11;  // increment before

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] sum;
    sum = '0;
    for (int i = 0; i < 16; i++) begin
      sum = sum + {4'd0, v[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/ldm_stm_seq_lsb.sv
// Lowest-set-bit selector: picks the register code transferred next.
// Ports:
//   i_vec  [15:0] remaining register list
//   o_code [3:0]  index of the lowest set bit (0 when the list is empty)
//   o_vld         at least one bit set
module lowest_set_bit (
  input  logic [15:0] i_vec,
  output logic [3:0]  o_code,
  output logic        o_vld
);

  always_comb begin
    o_code = '0;
    // Scan high to low so the last hit is the lowest index.
    for (int i = 15; i >= 0; i--) begin
      if (i_vec[i]) o_code = 4'(i);
    end
    o_vld = |i_vec;
  end

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer.
// Latches a block-transfer command, walks the register list lowest code
// first issuing one memory beat per register, returns loaded data on the
// WB write port and the updated base on the EX write port.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_start, i_load, i_pre, i_up, i_wb, i_rn_code, i_rn_reg, i_reg_list
//                                 command (LDM/STM, P/U/W bits, base, list)
//   o_busy, o_done                transfer in progress / completion pulse
//   o_re_code, i_re_reg           store-data register file read
//   o_mem_*, i_mem_ack, i_mem_rdata  memory request/ack handshake
//   o_rd_*_wb                     loaded-register write port
//   o_rd_*_ex                     base writeback port
module ldm_stm_seq
  import ldm_stm_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_load,
  input  logic        i_pre,
  input  logic        i_up,
  input  logic        i_wb,
  input  logic [3:0]  i_rn_code,
  input  logic [31:0] i_rn_reg,
  input  logic [15:0] i_reg_list,
  output logic        o_busy,
  output logic        o_done,
  output logic [3:0]  o_re_code,
  input  logic [31:0] i_re_reg,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_rd_en_wb,
  output logic [3:0]  o_rd_code_wb,
  output logic [31:0] o_rd_reg_wb,
  output logic        o_rd_en_ex,
  output logic [3:0]  o_rd_code_ex,
  output logic [31:0] o_rd_reg_ex
);

  state_t      state;
  logic        load_q;
  logic        wb_q;
  logic        suppress_q;
  logic [3:0]  rn_code_q;
  logic [15:0] list_q;
  logic [31:0] addr_q;
  logic [31:0] final_q;

  logic [4:0]  n;
  logic [31:0] span;
  logic [31:0] start_addr;
  logic [31:0] final_base;
  logic [3:0]  cur_code;
  logic        cur_vld;
  logic [15:0] list_next;
  logic        store_active;
  logic        beat_ack;

  lowest_set_bit u_lsb (
    .i_vec  (list_q),
    .o_code (cur_code),
    .o_vld  (cur_vld)
  );

  // Transfer footprint in bytes and the resulting address window.
  always_comb begin
    n    = popcount16(i_reg_list);
    span = {25'd0, n, 2'b00};
    start_addr = i_rn_reg;
    final_base = i_rn_reg + span;
    unique case (am_t'({i_pre, i_up}))
      AM_IA: begin
        start_addr = i_rn_reg;
        final_base = i_rn_reg + span;
      end
      AM_IB: begin
        start_addr = i_rn_reg + 32'd4;
        final_base = i_rn_reg + span;
      end
      AM_DA: begin
        start_addr = i_rn_reg - span + 32'd4;
        final_base = i_rn_reg - span;
      end
      AM_DB: begin
        start_addr = i_rn_reg - span;
        final_base = i_rn_reg - span;
      end
    endcase
  end

  assign list_next    = list_q & ~(16'h0001 << cur_code);
  assign store_active = (state == ST_XFER) && !load_q;
  assign beat_ack     = (state == ST_XFER) && i_mem_ack && cur_vld;

  // Store data is a straight combinational read of the register file.
  assign o_re_code   = store_active ? cur_code : 4'd0;
  assign o_mem_wdata = store_active ? i_re_reg : 32'd0;
  assign o_mem_addr  = addr_q;
  assign o_busy      = (state != ST_IDLE);

  // Final base value is pure data, only consumed after a fresh start.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && i_start) final_q <= final_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      load_q       <= 1'b0;
      wb_q         <= 1'b0;
      suppress_q   <= 1'b0;
      rn_code_q    <= '0;
      list_q       <= '0;
      addr_q       <= '0;
      o_done       <= 1'b0;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_rd_en_wb   <= 1'b0;
      o_rd_code_wb <= '0;
      o_rd_reg_wb  <= '0;
      o_rd_en_ex   <= 1'b0;
      o_rd_code_ex <= '0;
      o_rd_reg_ex  <= '0;
    end else begin
      o_done     <= 1'b0;
      o_rd_en_wb <= 1'b0;
      o_rd_en_ex <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (i_start) begin
            load_q    <= i_load;
            wb_q      <= i_wb;
            rn_code_q <= i_rn_code;
            list_q    <= i_reg_list;
            addr_q    <= start_addr;
            // Loaded base value wins over writeback; empty list writes nothing.
            suppress_q <= (n == 5'd0) || (i_load && i_reg_list[i_rn_code]);
            if (n == 5'd0) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
            end else begin
              state     <= ST_XFER;
              o_mem_req <= 1'b1;
              o_mem_we  <= !i_load;
            end
          end
        end
        ST_XFER: begin
          if (beat_ack) begin
            list_q <= list_next;
            addr_q <= addr_q + 32'd4;
            if (load_q) begin
              o_rd_en_wb   <= 1'b1;
              o_rd_code_wb <= cur_code;
              o_rd_reg_wb  <= i_mem_rdata;
            end
            if (list_next == 16'd0) begin
              state     <= ST_DONE;
              o_mem_req <= 1'b0;
              o_mem_we  <= 1'b0;
              o_done    <= 1'b1;
              if (wb_q && !suppress_q) begin
                o_rd_en_ex   <= 1'b1;
                o_rd_code_ex <= rn_code_q;
                o_rd_reg_ex  <= final_q;
              end
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed testbench for ldm_stm_seq: block loads/stores in all four
// addressing modes, wait-stated acks, empty list, busy-start and abort.
module tb_ldm_stm_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_load, i_pre, i_up, i_wb;
  logic [3:0]  i_rn_code;
  logic [31:0] i_rn_reg;
  logic [15:0] i_reg_list;
  logic        o_busy, o_done;
  logic [3:0]  o_re_code;
  logic [31:0] i_re_reg;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_rd_en_wb;
  logic [3:0]  o_rd_code_wb;
  logic [31:0] o_rd_reg_wb;
  logic        o_rd_en_ex;
  logic [3:0]  o_rd_code_ex;
  logic [31:0] o_rd_reg_ex;

  localparam logic [31:0] RF_TAG  = 32'hCAFE_0000;
  localparam logic [31:0] MEM_TAG = 32'h5A5A_0000;

  int total = 0;
  int bad   = 0;

  // Register file and memory models: data is a known function of code/address.
  assign i_re_reg    = RF_TAG | {28'd0, o_re_code};
  assign i_mem_rdata = o_mem_addr ^ MEM_TAG;

  always #5 clk = ~clk;

  ldm_stm_seq dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_load       (i_load),
    .i_pre        (i_pre),
    .i_up         (i_up),
    .i_wb         (i_wb),
    .i_rn_code    (i_rn_code),
    .i_rn_reg     (i_rn_reg),
    .i_reg_list   (i_reg_list),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_re_code    (o_re_code),
    .i_re_reg     (i_re_reg),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_ack    (i_mem_ack),
    .i_mem_rdata  (i_mem_rdata),
    .o_rd_en_wb   (o_rd_en_wb),
    .o_rd_code_wb (o_rd_code_wb),
    .o_rd_reg_wb  (o_rd_reg_wb),
    .o_rd_en_ex   (o_rd_en_ex),
    .o_rd_code_ex (o_rd_code_ex),
    .o_rd_reg_ex  (o_rd_reg_ex)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic ld, input logic p, input logic u, input logic w,
                           input logic [3:0] rn, input logic [31:0] base, input logic [15:0] list);
    i_load = ld; i_pre = p; i_up = u; i_wb = w;
    i_rn_code = rn; i_rn_reg = base; i_reg_list = list;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    // Scramble the command inputs to show they were latched.
    i_load = ~ld; i_pre = ~p; i_up = ~u; i_wb = ~w;
    i_rn_code = ~rn; i_rn_reg = 32'hDEAD_BEEF; i_reg_list = 16'hFFFF;
  endtask

  // One memory beat: request held for `waits` idle cycles, then acked.
  task automatic beat(input string tag, input logic we, input logic [31:0] a,
                      input logic [3:0] c, input int waits);
    for (int w = 0; w <= waits; w++) begin
      chk({tag, ".req"},  {31'd0, o_mem_req}, 32'd1);
      chk({tag, ".we"},   {31'd0, o_mem_we}, {31'd0, we});
      chk({tag, ".addr"}, o_mem_addr, a);
      if (we) begin
        chk({tag, ".re_code"}, {28'd0, o_re_code}, {28'd0, c});
        chk({tag, ".wdata"},   o_mem_wdata, RF_TAG | {28'd0, c});
      end
      i_mem_ack = (w == waits);
      tick();
    end
    i_mem_ack = 1'b0;
    if (!we) begin
      chk({tag, ".wb_en"},   {31'd0, o_rd_en_wb}, 32'd1);
      chk({tag, ".wb_code"}, {28'd0, o_rd_code_wb}, {28'd0, c});
      chk({tag, ".wb_reg"},  o_rd_reg_wb, a ^ MEM_TAG);
    end else begin
      chk({tag, ".wb_en"},   {31'd0, o_rd_en_wb}, 32'd0);
    end
  endtask

  // DONE cycle followed by the return to IDLE.
  task automatic done_chk(input string tag, input logic ex_en, input logic [3:0] ex_code,
                          input logic [31:0] ex_reg);
    chk({tag, ".done"},  {31'd0, o_done}, 32'd1);
    chk({tag, ".busy"},  {31'd0, o_busy}, 32'd1);
    chk({tag, ".req"},   {31'd0, o_mem_req}, 32'd0);
    chk({tag, ".ex_en"}, {31'd0, o_rd_en_ex}, {31'd0, ex_en});
    if (ex_en) begin
      chk({tag, ".ex_code"}, {28'd0, o_rd_code_ex}, {28'd0, ex_code});
      chk({tag, ".ex_reg"},  o_rd_reg_ex, ex_reg);
    end
    i_start = 1'b0;
    tick();
    chk({tag, ".done_off"},  {31'd0, o_done}, 32'd0);
    chk({tag, ".busy_off"},  {31'd0, o_busy}, 32'd0);
    chk({tag, ".ex_off"},    {31'd0, o_rd_en_ex}, 32'd0);
    chk({tag, ".wb_off"},    {31'd0, o_rd_en_wb}, 32'd0);
    chk({tag, ".req_off"},   {31'd0, o_mem_req}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_load = 1'b0; i_pre = 1'b0; i_up = 1'b0; i_wb = 1'b0;
    i_rn_code = '0; i_rn_reg = '0; i_reg_list = '0; i_mem_ack = 1'b0;
    tick();
    tick();
    chk("rst.busy",    {31'd0, o_busy}, 32'd0);
    chk("rst.done",    {31'd0, o_done}, 32'd0);
    chk("rst.req",     {31'd0, o_mem_req}, 32'd0);
    chk("rst.we",      {31'd0, o_mem_we}, 32'd0);
    chk("rst.wb_en",   {31'd0, o_rd_en_wb}, 32'd0);
    chk("rst.ex_en",   {31'd0, o_rd_en_ex}, 32'd0);
    chk("rst.addr",    o_mem_addr, 32'd0);
    chk("rst.wdata",   o_mem_wdata, 32'd0);
    chk("rst.codes",   {20'd0, o_re_code, o_rd_code_wb, o_rd_code_ex}, 32'd0);
    chk("rst.regs",    o_rd_reg_wb | o_rd_reg_ex, 32'd0);
    rst = 1'b0;
    tick();

    // LDMIA r0!,{r1,r2,r4}, r0=0x1000
    start_cmd(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 32'h0000_1000, 16'h0016);
    chk("ldmia.busy", {31'd0, o_busy}, 32'd1);
    beat("ldmia.b0", 1'b0, 32'h0000_1000, 4'd1, 0);
    beat("ldmia.b1", 1'b0, 32'h0000_1004, 4'd2, 0);
    beat("ldmia.b2", 1'b0, 32'h0000_1008, 4'd4, 0);
    done_chk("ldmia", 1'b1, 4'd0, 32'h0000_100C);

    // STMDB r13!,{r4,r14}, r13=0x2000
    start_cmd(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 32'h0000_2000, 16'h4010);
    beat("stmdb.b0", 1'b1, 32'h0000_1FF8, 4'd4, 0);
    beat("stmdb.b1", 1'b1, 32'h0000_1FFC, 4'd14, 0);
    done_chk("stmdb", 1'b1, 4'd13, 32'h0000_1FF8);

    // LDMIB r3!,{r3,r5}, r3=0x400: loaded base wins, no EX write
    start_cmd(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 32'h0000_0400, 16'h0028);
    beat("ldmib.b0", 1'b0, 32'h0000_0404, 4'd3, 0);
    beat("ldmib.b1", 1'b0, 32'h0000_0408, 4'd5, 0);
    done_chk("ldmib", 1'b0, 4'd0, 32'd0);

    // STMIA r2,{r0,r1,r8} with 3 wait states per beat; start held high while busy
    start_cmd(1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 32'h0000_3000, 16'h0103);
    i_start = 1'b1; i_reg_list = 16'h00F0;
    beat("stmia.b0", 1'b1, 32'h0000_3000, 4'd0, 3);
    beat("stmia.b1", 1'b1, 32'h0000_3004, 4'd1, 3);
    beat("stmia.b2", 1'b1, 32'h0000_3008, 4'd8, 3);
    done_chk("stmia", 1'b0, 4'd0, 32'd0);

    // LDMDA r5!,{r0,r1,pc}, r5=4: address wraps below zero, code 15 loaded
    start_cmd(1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 32'h0000_0004, 16'h8003);
    beat("ldmda.b0", 1'b0, 32'hFFFF_FFFC, 4'd0, 0);
    beat("ldmda.b1", 1'b0, 32'h0000_0000, 4'd1, 1);
    beat("ldmda.b2", 1'b0, 32'h0000_0004, 4'd15, 0);
    done_chk("ldmda", 1'b1, 4'd5, 32'hFFFF_FFF8);

    // Empty list: done next cycle, no request; start during DONE ignored
    start_cmd(1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 32'h0000_7000, 16'h0000);
    i_start = 1'b1; i_reg_list = 16'h0001;
    done_chk("empty", 1'b0, 4'd0, 32'd0);

    // Abort: reset after the first ack of a 4-register LDM
    start_cmd(1'b1, 1'b0, 1'b1, 1'b1, 4'd6, 32'h0000_5000, 16'h000F);
    beat("abort.b0", 1'b0, 32'h0000_5000, 4'd0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.req",  {31'd0, o_mem_req}, 32'd0);
    chk("abort.busy", {31'd0, o_busy}, 32'd0);
    i_mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("abort.wb_en", {31'd0, o_rd_en_wb}, 32'd0);
      chk("abort.ex_en", {31'd0, o_rd_en_ex}, 32'd0);
      chk("abort.done",  {31'd0, o_done}, 32'd0);
      tick();
    end
    i_mem_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
